// File: rtl/d_ff_enable.sv
// Edge-triggered register with synchronous active-low reset and load enable.
// Optional hidden parity bit and checker under `D_FF_ENABLE_PARITY_EN.
module d_ff_enable #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             enable,
`ifdef D_FF_ENABLE_PARITY_EN
  output logic             q_par,
  output logic             par_err,
`endif
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else if (enable) begin
      q <= d;
    end
  end

`ifdef D_FF_ENABLE_PARITY_EN
  logic par_q;

  // Parity tracks every write to q so a flipped stored bit shows up on par_err.
  always_ff @(posedge clk) begin
    if (!reset) begin
      par_q <= ^RESET_VAL;
    end else if (enable) begin
      par_q <= ^d;
    end
  end

  assign q_par   = par_q;
  assign par_err = (^q) ^ par_q;
`endif

endmodule

// File: tb/tb_d_ff_enable.sv
// Scoreboard bench for d_ff_enable at widths 1, 8 and 64.
// Parity checks are built when D_FF_ENABLE_PARITY_EN is defined.
module tb_d_ff_enable;

  localparam logic [7:0] RV8 = 8'h5A;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [63:0] d = '0;
  logic [0:0]  q1;
  logic [7:0]  q8;
  logic [63:0] q64;
`ifdef D_FF_ENABLE_PARITY_EN
  logic qp1, pe1, qp8, pe8, qp64, pe64;
`endif

  always #5 clk = ~clk;

  d_ff_enable #(.WIDTH(1)) u1 (
    .clk(clk), .reset(reset), .d(d[0:0]), .enable(enable),
`ifdef D_FF_ENABLE_PARITY_EN
    .q_par(qp1), .par_err(pe1),
`endif
    .q(q1)
  );

  d_ff_enable #(.WIDTH(8), .RESET_VAL(RV8)) u8 (
    .clk(clk), .reset(reset), .d(d[7:0]), .enable(enable),
`ifdef D_FF_ENABLE_PARITY_EN
    .q_par(qp8), .par_err(pe8),
`endif
    .q(q8)
  );

  d_ff_enable #(.WIDTH(64)) u64 (
    .clk(clk), .reset(reset), .d(d), .enable(enable),
`ifdef D_FF_ENABLE_PARITY_EN
    .q_par(qp64), .par_err(pe64),
`endif
    .q(q64)
  );

  typedef struct {
    logic [63:0] q;
    logic [7:0]  q8;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m64;
  logic [7:0]  m8;
  int          total = 0;
  int          passed = 0;
  bit          done = 1'b0;

  function automatic logic [63:0] nxt(input logic [63:0] prev,
                                      input logic r, input logic e,
                                      input logic [63:0] dv,
                                      input logic [63:0] rv);
    if (!r) return rv;
    if (e) return dv;
    return prev;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic step(input logic r, input logic e, input logic [63:0] dv,
                      input string tag);
    exp_t x;
    @(negedge clk);
    reset  = r;
    enable = e;
    d      = dv;
    m64  = nxt(m64, r, e, dv, 64'h0);
    m8   = 8'(nxt({56'h0, m8}, r, e, {56'h0, dv[7:0]}, {56'h0, RV8}));
    x.q  = m64;
    x.q8 = m8;
    x.tag = tag;
    sb.push_back(x);
  endtask

  // Monitor: every edge presents a new q; compare against the queued model.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.tag, " q1"}, {63'h0, q1}, {63'h0, e.q[0]});
        chk({e.tag, " q8"}, {56'h0, q8}, {56'h0, e.q8});
        chk({e.tag, " q64"}, q64, e.q);
`ifdef D_FF_ENABLE_PARITY_EN
        chk({e.tag, " q_par8"}, {63'h0, qp8}, {63'h0, ^e.q8});
        chk({e.tag, " par_err8"}, {63'h0, pe8}, 64'h0);
        chk({e.tag, " par_err64"}, {63'h0, pe64}, 64'h0);
        chk({e.tag, " par_err1"}, {63'h0, pe1}, 64'h0);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    m64 = '0;
    m8  = '0;
    step(1'b0, 1'b1, '1, "reset");
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, '1, "hold_after_reset");
    step(1'b1, 1'b1, '1, "load_ones");
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, '0, "hold_ones");
    step(1'b1, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, "aa_disabled");
    step(1'b1, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, "aa_load");
    step(1'b1, 1'b0, 64'hBBBB_BBBB_BBBB_BBBB, "bb_disabled");
    step(1'b1, 1'b1, 64'hBBBB_BBBB_BBBB_BBBB, "bb_load");
    step(1'b0, 1'b1, '1, "reset_wins");
    step(1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, "reload");

    // Wiggle d between edges: q must not move until the edge.
    @(negedge clk);
    enable = 1'b1;
    d = 64'h0F0F_0F0F_0F0F_0F0F;
    #1 chk("mid_edge_a", q64, m64);
    d = 64'hCAFE_F00D_DEAD_BEEF;
    #1 chk("mid_edge_b", q64, m64);
    chk("mid_edge_b8", {56'h0, q8}, {56'h0, m8});
    m64 = d;
    m8  = d[7:0];
    sb.push_back('{q: m64, q8: m8, tag: "mid_edge_load"});

    step(1'b1, 1'b1, 64'h7, "load_07");
`ifdef D_FF_ENABLE_PARITY_EN
    @(negedge clk);
    force u8.par_q = 1'b0;
    #1;
    chk("forced q_par8", {63'h0, qp8}, 64'h0);
    chk("forced par_err8", {63'h0, pe8}, 64'h1);
    release u8.par_q;
`endif
    step(1'b1, 1'b1, 64'h7, "reload_07");

    for (int i = 0; i < 300; i++)
      step(($urandom_range(15) != 0), $urandom_range(1),
           {$urandom, $urandom}, "random");

    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
